// File: rtl/timer_uart_pkg.sv
// Shared constants, state encodings and the BCD-to-ASCII helper for the timer serial reporter.
package timer_uart_pkg;

   localparam logic [7:0] ZERO  = 8'h30;
   localparam logic [7:0] COLON = 8'h3A;
   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] BANG  = 8'h21;
   localparam logic [7:0] QMARK = 8'h3F;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;

   localparam int FRAME_LEN     = 8;
   localparam int BITS_PER_BYTE = 8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CTS,
      START,
      DATA,
      STOP
   } frameState_e;

   typedef enum logic [1:0] {
      BIT_IDLE,
      BIT_START,
      BIT_DATA,
      BIT_STOP
   } bitPhase_e;

   // Digits above 9 cannot be shown as a decimal character, so they become '?'.
   function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
      return (d <= 4'd9) ? (ZERO + {4'b0000, d}) : QMARK;
   endfunction

endpackage

// File: rtl/timer_uart_tx_byte.sv
// One-byte 8N1 serializer: a go pulse starts start/data/stop, with phase-end pulses back to the frame FSM.
module uart_tx_byte
   import timer_uart_pkg::*;
#(
   parameter int DIV = 16
)
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       go_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       startEnd_o,
   output logic       dataEnd_o,
   output logic       done_o
);

   localparam int            CW        = $clog2(DIV);
   localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(BITS_PER_BYTE - 1);

   bitPhase_e     phase_q, phase_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bitIdx_q, bitIdx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bitEnd;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         phase_q  <= BIT_IDLE;
         baud_q   <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         phase_q  <= phase_d;
         baud_q   <= baud_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   // The line level is decided one cycle ahead so TX comes straight from a flop.
   always_comb begin
      phase_d    = phase_q;
      baud_d     = baud_q;
      bitIdx_d   = bitIdx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      startEnd_o = 1'b0;
      dataEnd_o  = 1'b0;
      done_o     = 1'b0;
      bitEnd     = (baud_q == LAST_TICK);

      case (phase_q)
         BIT_IDLE: begin
            tx_d = 1'b1;
            if (go_i) begin
               phase_d = BIT_START;
               shift_d = data_i;
               baud_d  = '0;
               tx_d    = 1'b0;
            end
         end
         BIT_START: begin
            if (bitEnd) begin
               baud_d     = '0;
               bitIdx_d   = '0;
               phase_d    = BIT_DATA;
               tx_d       = shift_q[0];
               startEnd_o = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         BIT_DATA: begin
            if (bitEnd) begin
               baud_d = '0;
               if (bitIdx_q == LAST_BIT) begin
                  phase_d   = BIT_STOP;
                  tx_d      = 1'b1;
                  dataEnd_o = 1'b1;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
                  shift_d  = {1'b0, shift_q[7:1]};
                  tx_d     = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         BIT_STOP: begin
            if (bitEnd) begin
               baud_d  = '0;
               phase_d = BIT_IDLE;
               done_o  = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            phase_d = BIT_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx_o = tx_q;

endmodule

// File: rtl/timer_uart_tx.sv
// Sends the latched MM:SS time and ended flag as an 8-byte ASCII line, gated by CTS at each byte boundary.
module timer_uart_tx
   import timer_uart_pkg::*;
#(
   parameter int CLK_HZ = 25175000,
   parameter int BAUD   = 9600
)
(
   input  logic       MCLK,
   input  logic       RST,
   input  logic       SEND,
   input  logic [2:0] MIN_1,
   input  logic [3:0] MIN_0,
   input  logic [2:0] SEC_1,
   input  logic [3:0] SEC_0,
   input  logic       ENDED,
   input  logic       CTS,
   output logic       TX,
   output logic       BUSY
);

   localparam int         DIV        = (CLK_HZ + BAUD / 2) / BAUD;
   localparam logic [2:0] LAST_INDEX = 3'(FRAME_LEN - 1);

   frameState_e state_q, state_d;
   logic [2:0]  index_q, index_d;
   logic        busy_q, busy_d;
   logic        ctsMeta_q, ctsSync_q;
   logic [2:0]  min1_q, sec1_q;
   logic [3:0]  min0_q, sec0_q;
   logic        ended_q;
   logic        accept;
   logic        go;
   logic [7:0]  byteData;
   logic        byteTx, startEnd, dataEnd, byteDone;

   uart_tx_byte #(
      .DIV (DIV)
   ) byteTxInst (
      .clk_i      (MCLK),
      .reset_i    (RST),
      .go_i       (go),
      .data_i     (byteData),
      .tx_o       (byteTx),
      .startEnd_o (startEnd),
      .dataEnd_o  (dataEnd),
      .done_o     (byteDone)
   );

   // CTS is asynchronous to MCLK, so only the second flop is ever looked at.
   always_ff @(posedge MCLK) begin
      if (RST) begin
         state_q   <= IDLE;
         index_q   <= '0;
         busy_q    <= 1'b0;
         ctsMeta_q <= 1'b0;
         ctsSync_q <= 1'b0;
         min1_q    <= '0;
         min0_q    <= '0;
         sec1_q    <= '0;
         sec0_q    <= '0;
         ended_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         busy_q    <= busy_d;
         ctsMeta_q <= CTS;
         ctsSync_q <= ctsMeta_q;
         if (accept) begin
            min1_q  <= MIN_1;
            min0_q  <= MIN_0;
            sec1_q  <= SEC_1;
            sec0_q  <= SEC_0;
            ended_q <= ENDED;
         end
      end
   end

   // Frame sequencing; bit timing lives in the serializer, which reports each phase end.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      busy_d  = busy_q;
      accept  = 1'b0;
      go      = 1'b0;

      case (state_q)
         IDLE: begin
            if (SEND) begin
               accept  = 1'b1;
               index_d = '0;
               busy_d  = 1'b1;
               state_d = WAIT_CTS;
            end
         end
         WAIT_CTS: begin
            if (ctsSync_q) begin
               go      = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (startEnd) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (dataEnd) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (byteDone) begin
               if (index_q == LAST_INDEX) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = WAIT_CTS;
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Byte mux for the "MM:SSs\r\n" line; the tens digits are only 3 bits wide.
   always_comb begin
      byteData = LF;
      case (index_q)
         3'd0:    byteData = bcd_ascii({1'b0, min1_q});
         3'd1:    byteData = bcd_ascii(min0_q);
         3'd2:    byteData = COLON;
         3'd3:    byteData = bcd_ascii({1'b0, sec1_q});
         3'd4:    byteData = bcd_ascii(sec0_q);
         3'd5:    byteData = ended_q ? BANG : SPACE;
         3'd6:    byteData = CR;
         default: byteData = LF;
      endcase
   end

   assign TX   = byteTx;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_timer_uart_tx.sv
// Directed and randomized frames checked against an ASCII frame model and a line-level UART receiver.
module tb_timer_uart_tx;

   localparam int CLK_HZ     = 16;
   localparam int BAUD       = 1;
   localparam int DIV        = 16;
   localparam int FRAME_CYC  = 8 * (10 * DIV + 1);

   logic       mclk = 1'b0;
   logic       rst;
   logic       send;
   logic [2:0] min1;
   logic [3:0] min0;
   logic [2:0] sec1;
   logic [3:0] sec0;
   logic       ended;
   logic       cts;
   logic       tx;
   logic       busy;

   int cyc        = 0;
   int passCount  = 0;
   int totalCount = 0;
   int failCount  = 0;
   int startCyc [8];

   timer_uart_tx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .MCLK  (mclk),
      .RST   (rst),
      .SEND  (send),
      .MIN_1 (min1),
      .MIN_0 (min0),
      .SEC_1 (sec1),
      .SEC_0 (sec0),
      .ENDED (ended),
      .CTS   (cts),
      .TX    (tx),
      .BUSY  (busy)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge mclk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Reference: the line a host should see for these inputs.
   function automatic logic [7:0] digitChar(input int d);
      return (d < 10) ? 8'(48 + d) : 8'h3F;
   endfunction

   function automatic logic [63:0] expectFrame(input int m1, input int m0, input int s1,
                                               input int s0, input logic e);
      logic [63:0] f;
      f[7:0]   = digitChar(m1);
      f[15:8]  = digitChar(m0);
      f[23:16] = 8'h3A;
      f[31:24] = digitChar(s1);
      f[39:32] = digitChar(s0);
      f[47:40] = e ? 8'h21 : 8'h20;
      f[55:48] = 8'h0D;
      f[63:56] = 8'h0A;
      return f;
   endfunction

   task automatic applyStimulus(input logic [2:0] m1, input logic [3:0] m0, input logic [2:0] s1,
                                input logic [3:0] s0, input logic e);
      min1  = m1;
      min0  = m0;
      sec1  = s1;
      sec0  = s0;
      ended = e;
      send  = 1'b1;
      tick(1);
      send  = 1'b0;
   endtask

   task automatic recvByte(output logic [7:0] b, output int startC, output logic stopBit,
                           output logic ok);
      int w = 0;
      b       = 8'h00;
      startC  = -1;
      stopBit = 1'b0;
      ok      = 1'b0;
      while (tx !== 1'b0 && w < 3000) begin
         tick(1);
         w++;
      end
      if (tx === 1'b0) begin
         ok     = 1'b1;
         startC = cyc;
         tick(DIV / 2);
         for (int k = 0; k < 8; k++) begin
            tick(DIV);
            b[k] = tx;
         end
         tick(DIV);
         stopBit = tx;
      end
   endtask

   task automatic recvFrame(input logic [63:0] exp, input string tag);
      logic [7:0] b;
      int         sc;
      logic       stopBit;
      logic       ok;
      for (int i = 0; i < 8; i++) begin
         recvByte(b, sc, stopBit, ok);
         startCyc[i] = sc;
         checkOutput($sformatf("%s.startSeen%0d", tag, i), ok, 1'b1);
         if (!ok) return;
         checkOutput($sformatf("%s.byte%0d", tag, i), b, exp[8*i +: 8]);
         checkOutput($sformatf("%s.stop%0d", tag, i), stopBit, 1'b1);
      end
   endtask

   task automatic measureBusy(output int w);
      w = 0;
      while (busy === 1'b1 && w < 20000) begin
         tick(1);
         w++;
      end
   endtask

   initial begin
      logic [63:0] exp;
      logic [2:0]  r1, r3;
      logic [3:0]  r0, r2;
      logic        re;
      logic        prevTx;
      int          edges;
      int          width;
      int          k;
      int          lowCnt;
      int          riseCyc;

      rst   = 1'b1;
      send  = 1'b0;
      min1  = '0;
      min0  = '0;
      sec1  = '0;
      sec0  = '0;
      ended = 1'b0;
      cts   = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(5);

      // Reset while idle, then a quiet line
      rst = 1'b1;
      tick(1);
      checkOutput("resetTx", tx, 1'b1);
      checkOutput("resetBusy", busy, 1'b0);
      rst    = 1'b0;
      edges  = 0;
      prevTx = tx;
      repeat (200) begin
         tick(1);
         if (tx !== prevTx) edges++;
         prevTx = tx;
      end
      checkOutput("idleTxEdges", edges, 0);
      checkOutput("idleBusy", busy, 1'b0);

      // Nominal frame 12:34
      applyStimulus(3'd1, 4'd2, 3'd3, 4'd4, 1'b0);
      checkOutput("busyRise", busy, 1'b1);
      checkOutput("txBeforeStart", tx, 1'b1);
      fork
         begin
            tick(1);
            checkOutput("startAtN2", tx, 1'b0);
            recvFrame(expectFrame(1, 2, 3, 4, 1'b0), "nominal");
            checkOutput("byteSpacing", startCyc[1] - startCyc[0], 10 * DIV + 1);
         end
         measureBusy(width);
      join
      checkOutput("nominalBusyWidth", width, FRAME_CYC);

      // Ended flag
      applyStimulus(3'd0, 4'd0, 3'd0, 4'd0, 1'b1);
      fork
         recvFrame(expectFrame(0, 0, 0, 0, 1'b1), "ended");
         measureBusy(width);
      join
      checkOutput("endedBusyWidth", width, FRAME_CYC);

      // Invalid digits, inputs disturbed mid-frame
      r1 = 3'($urandom_range(7, 0));
      r3 = 3'($urandom_range(7, 0));
      re = 1'($urandom_range(1, 0));
      exp = expectFrame(int'(r1), 12, int'(r3), 15, re);
      applyStimulus(r1, 4'hC, r3, 4'hF, re);
      fork
         recvFrame(exp, "invalid");
         measureBusy(width);
         begin
            tick(40);
            min1  = 3'($urandom);
            min0  = 4'($urandom);
            sec1  = 3'($urandom);
            sec0  = 4'($urandom);
            ended = ~ended;
            tick(500);
            min0  = 4'd9;
            sec0  = 4'd1;
            ended = ~ended;
         end
      join
      checkOutput("invalidBusyWidth", width, FRAME_CYC);

      // Randomized back-to-back frames: each SEND lands in the cycle BUSY falls
      repeat (3) begin
         r1 = 3'($urandom_range(7, 0));
         r0 = 4'($urandom_range(15, 0));
         r3 = 3'($urandom_range(7, 0));
         r2 = 4'($urandom_range(15, 0));
         re = 1'($urandom_range(1, 0));
         exp = expectFrame(int'(r1), int'(r0), int'(r3), int'(r2), re);
         applyStimulus(r1, r0, r3, r2, re);
         checkOutput("backToBackBusy", busy, 1'b1);
         fork
            recvFrame(exp, "random");
            measureBusy(width);
         join
         checkOutput("randomBusyWidth", width, FRAME_CYC);
      end

      // SEND while busy is neither applied nor queued
      exp = expectFrame(5, 9, 2, 7, 1'b0);
      applyStimulus(3'd5, 4'd9, 3'd2, 4'd7, 1'b0);
      fork
         recvFrame(exp, "ignore");
         measureBusy(width);
         repeat (5) begin
            tick(200);
            min1  = 3'($urandom);
            min0  = 4'($urandom);
            sec1  = 3'($urandom);
            sec0  = 4'($urandom);
            ended = 1'b1;
            send  = 1'b1;
            tick(1);
            send  = 1'b0;
         end
      join
      checkOutput("ignoreBusyWidth", width, FRAME_CYC);
      tick(5);
      checkOutput("notQueuedBusy", busy, 1'b0);
      checkOutput("notQueuedTx", tx, 1'b1);

      // CTS low at SEND: busy but silent until CTS rises
      cts = 1'b0;
      tick(3);
      exp = expectFrame(4, 3, 1, 0, 1'b1);
      applyStimulus(3'd4, 4'd3, 3'd1, 4'd0, 1'b1);
      checkOutput("ctsLowBusy", busy, 1'b1);
      lowCnt = 0;
      repeat (100) begin
         tick(1);
         if (tx !== 1'b1) lowCnt++;
      end
      checkOutput("ctsLowTxQuiet", lowCnt, 0);
      checkOutput("ctsLowStillBusy", busy, 1'b1);
      cts = 1'b1;
      k = 0;
      while (tx !== 1'b0 && k < 50) begin
         tick(1);
         k++;
      end
      checkOutput("ctsRiseToStart", k, 3);
      fork
         recvFrame(exp, "ctsHeld");
         measureBusy(width);
      join

      // CTS dropped during byte 3
      riseCyc = 0;
      exp = expectFrame(2, 8, 5, 6, 1'b0);
      applyStimulus(3'd2, 4'd8, 3'd5, 4'd6, 1'b0);
      fork
         recvFrame(exp, "ctsDrop");
         measureBusy(width);
         begin
            tick(373);
            cts = 1'b0;
            tick(300);
            cts = 1'b1;
            riseCyc = cyc;
         end
      join
      checkOutput("byte3Unaffected", startCyc[2] - startCyc[1], 10 * DIV + 1);
      checkOutput("byte4AfterCts", startCyc[3] - riseCyc, 3);

      // Reset during data bits of byte 2, then a fresh frame
      applyStimulus(3'd0, 4'd0, 3'd6, 4'd1, 1'b0);
      tick(185);
      checkOutput("txLowBeforeReset", tx, 1'b0);
      rst = 1'b1;
      tick(1);
      checkOutput("abortTx", tx, 1'b1);
      checkOutput("abortBusy", busy, 1'b0);
      rst = 1'b0;
      tick(3);
      checkOutput("afterAbortBusy", busy, 1'b0);
      checkOutput("afterAbortTx", tx, 1'b1);
      r1 = 3'($urandom_range(7, 0));
      r0 = 4'($urandom_range(9, 0));
      r3 = 3'($urandom_range(5, 0));
      r2 = 4'($urandom_range(9, 0));
      exp = expectFrame(int'(r1), int'(r0), int'(r3), int'(r2), 1'b1);
      applyStimulus(r1, r0, r3, r2, 1'b1);
      fork
         recvFrame(exp, "fresh");
         measureBusy(width);
      join
      checkOutput("freshBusyWidth", width, FRAME_CYC);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
